// File: rtl/vx_mem_rsp_packer_pkg.sv
// vx_mem_rsp_pkg: shared beat/line geometry and line-entry types for the response packer
`ifndef VX_MEM_TAG_WIDTH
`define VX_MEM_TAG_WIDTH 8
`endif

package vx_mem_rsp_pkg;
    localparam int MEM_RSP_BEATS  = 8;
    localparam int MEM_RSP_BEAT_W = 64;
    localparam int MEM_RSP_TAG_W  = `VX_MEM_TAG_WIDTH;
    typedef logic [MEM_RSP_BEATS*MEM_RSP_BEAT_W-1:0] line_t;
    typedef struct packed {
        logic [MEM_RSP_TAG_W-1:0] tag;
        line_t                    line;
    } rsp_line_t;
endpackage

// File: rtl/vx_mem_rsp_packer_if.sv
// vx_mem_rsp_packer_if: response beat stream in, assembled line fill port and status out
interface vx_mem_rsp_packer_if
    import vx_mem_rsp_pkg::*;
#(
    parameter int DATA_WIDTH = MEM_RSP_BEAT_W,
    parameter int TAG_WIDTH  = MEM_RSP_TAG_W,
    parameter int BEATS      = MEM_RSP_BEATS
);
    logic                        mem_rsp_valid;
    logic [DATA_WIDTH-1:0]       mem_rsp_data;
    logic [TAG_WIDTH-1:0]        mem_rsp_tag;
    logic                        line_valid;
    logic                        line_ready;
    logic [BEATS*DATA_WIDTH-1:0] line_data;
    logic [TAG_WIDTH-1:0]        line_tag;
    logic                        space_avail;
    logic                        overflow;
    logic                        tag_err;

    modport master (
        output mem_rsp_valid, mem_rsp_data, mem_rsp_tag, line_ready,
        input  line_valid, line_data, line_tag, space_avail, overflow, tag_err
    );
    modport slave (
        input  mem_rsp_valid, mem_rsp_data, mem_rsp_tag, line_ready,
        output line_valid, line_data, line_tag, space_avail, overflow, tag_err
    );
endinterface

// File: rtl/vx_mem_rsp_packer_fifo.sv
// vx_mem_rsp_line_fifo: flop-based FIFO of completed lines; push while full is legal only with a pop
module vx_mem_rsp_line_fifo
    import vx_mem_rsp_pkg::*;
#(
    parameter int WIDTH = $bits(rsp_line_t),
    parameter int DEPTH = 2,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr, wr_ptr;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign head  = mem[rd_ptr];
    assign full  = count == CW'(DEPTH);
    assign empty = count == '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (pop) rd_ptr <= nxt(rd_ptr);
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= nxt(wr_ptr);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end
endmodule

// File: rtl/vx_mem_rsp_packer.sv
// vx_mem_rsp_packer: assembles fixed-length response bursts into lines and queues them for the fill port
module vx_mem_rsp_packer
    import vx_mem_rsp_pkg::*;
#(
    parameter int DATA_WIDTH = MEM_RSP_BEAT_W,
    parameter int TAG_WIDTH  = `VX_MEM_TAG_WIDTH,
    parameter int BEATS      = MEM_RSP_BEATS,
    parameter int DEPTH      = 2
) (
    input logic                clk,
    input logic                reset_n,
    vx_mem_rsp_packer_if.slave bus
);
    localparam int CW = $clog2(BEATS);
    localparam int QW = $clog2(DEPTH + 1);
    localparam int LW = BEATS * DATA_WIDTH;

    logic [CW-1:0]           beat_cnt;
    logic [DATA_WIDTH-1:0]   stage [BEATS-1];
    logic [TAG_WIDTH-1:0]    cap_tag;
    logic                    overflow, tag_err;
    logic [LW-1:0]           line_in;
    logic [LW+TAG_WIDTH-1:0] head;
    logic [QW-1:0]           count;
    logic                    full, empty, last_beat, push, pop;

    assign last_beat = bus.mem_rsp_valid && beat_cnt == CW'(BEATS - 1);
    assign pop       = !empty && bus.line_ready;
    assign push      = last_beat && (!full || pop);

    // The final beat bypasses staging and lands in the line straight from the bus.
    always_comb begin
        line_in = '0;
        for (int i = 0; i < BEATS - 1; i++) line_in[i*DATA_WIDTH +: DATA_WIDTH] = stage[i];
        line_in[LW-1 -: DATA_WIDTH] = bus.mem_rsp_data;
    end

    vx_mem_rsp_line_fifo #(.WIDTH(LW + TAG_WIDTH), .DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push),
        .push_data ({cap_tag, line_in}),
        .pop       (pop),
        .head      (head),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            beat_cnt <= '0;
            cap_tag  <= '0;
            overflow <= 1'b0;
            tag_err  <= 1'b0;
            for (int i = 0; i < BEATS - 1; i++) stage[i] <= '0;
        end else begin
            if (bus.mem_rsp_valid) begin
                beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
                if (beat_cnt == '0) cap_tag <= bus.mem_rsp_tag;
                if (!last_beat) stage[beat_cnt] <= bus.mem_rsp_data;
                if (beat_cnt != '0 && bus.mem_rsp_tag != cap_tag) tag_err <= 1'b1;
            end
            if (last_beat && !push) overflow <= 1'b1;
        end
    end

    // A partially assembled burst already claims one FIFO slot.
    assign bus.space_avail = (int'(count) + int'(beat_cnt != '0)) < DEPTH;
    assign bus.line_valid  = !empty;
    assign bus.line_data   = head[LW-1:0];
    assign bus.line_tag    = head[LW +: TAG_WIDTH];
    assign bus.overflow    = overflow;
    assign bus.tag_err     = tag_err;
endmodule
